i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/sync_edge.sv | 28 ++
 rtl/i2s_rx.sv | 115 +++++++++++
 tb/tb_i2s_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S definitions for the receiver and transmitter
package i2s_pkg;

    localparam int SAMPLE_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } i2s_state_e;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    function automatic logic chan_of(input logic lrck_level);
        return lrck_level ? RIGHT : LEFT;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop input synchronizer with rising-edge detect
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: oversampled bck/lrck/data, word capture per channel slot
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                mck,
    input  logic                rst_n,
    input  logic                bck,
    input  logic                lrck,
    input  logic                i2s_data,
    output logic [SAMPLE_W-1:0] sample,
    output logic                chan,
    output logic                sample_valid,
    output logic                frame_err
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);

    logic bck_rise, lrck_s, data_s;
    logic bck_sync_unused, lrck_rise_unused, data_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_bck (
        .clk_i (mck), .rst_ni(rst_n), .d_i(bck),
        .sync_o(bck_sync_unused), .rise_o(bck_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_lrck (
        .clk_i (mck), .rst_ni(rst_n), .d_i(lrck),
        .sync_o(lrck_s), .rise_o(lrck_rise_unused)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_data (
        .clk_i (mck), .rst_ni(rst_n), .d_i(i2s_data),
        .sync_o(data_s), .rise_o(data_rise_unused)
    );

    i2s_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SAMPLE_W-1:0] shreg_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic                lrck_prev_q, primed_q, slot_ch_q;
    logic                chan_q, valid_q, err_q;

    logic [SAMPLE_W-1:0] shreg_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                slot_start, word_done;

    // The first bck_rise after reset only records lrck, so a reset landing
    // inside a slot never fabricates a slot start from the cleared history.
    assign slot_start = bck_rise & primed_q & (lrck_s != lrck_prev_q);
    assign shreg_d    = {shreg_q[SAMPLE_W-2:0], data_s};
    assign cnt_d      = cnt_q + 1'b1;
    assign word_done  = (cnt_q == CNT_W'(SAMPLE_W - 1));

    // The bck_rise that reveals an lrck change carries the previous slot's last
    // bit (the I2S one-bit delay), so entering DELAY consumes it; the MSB of the
    // new slot arrives on the rise taken in DELAY.
    always_ff @(posedge mck) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            sample_q    <= '0;
            lrck_prev_q <= LEFT;
            primed_q    <= 1'b0;
            slot_ch_q   <= LEFT;
            chan_q      <= LEFT;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (bck_rise) begin
                primed_q    <= 1'b1;
                lrck_prev_q <= lrck_s;
                if (slot_start) begin
                    slot_ch_q <= chan_of(lrck_s);
                end
                case (state_q)
                    IDLE, HOLD: begin
                        if (slot_start) begin
                            state_q <= DELAY;
                            cnt_q   <= '0;
                        end
                    end
                    DELAY, SHIFT: begin
                        if (word_done) begin
                            // A 24-bit slot's LSB shares its rise with the next lrck edge.
                            sample_q <= shreg_d;
                            chan_q   <= slot_ch_q;
                            valid_q  <= 1'b1;
                            state_q  <= slot_start ? DELAY : HOLD;
                            cnt_q    <= slot_start ? '0 : CNT_W'(SAMPLE_W);
                        end else if (slot_start) begin
                            err_q   <= 1'b1;
                            state_q <= DELAY;
                            cnt_q   <= '0;
                        end else begin
                            shreg_q <= shreg_d;
                            cnt_q   <= cnt_d;
                            state_q <= SHIFT;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sample       = sample_q;
    assign chan         = chan_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - self-checking bench for i2s_rx with a slot-level protocol model
module tb_i2s_rx;

    localparam int W = 24;

    logic          mck, rst_n, bck, lrck, i2s_data;
    logic [W-1:0]  sample;
    logic          chan, sample_valid, frame_err;

    i2s_rx #(.SAMPLE_W(W), .SYNC_STAGES(2)) dut (
        .mck(mck), .rst_n(rst_n), .bck(bck), .lrck(lrck), .i2s_data(i2s_data),
        .sample(sample), .chan(chan), .sample_valid(sample_valid), .frame_err(frame_err)
    );

    initial mck = 1'b0;
    always #1 mck = ~mck;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit           is_err;
        logic [W-1:0] word;
        logic         ch;
    } ev_t;
    ev_t exp_q[$];

    // Protocol model: bits belong to the slot opened by the last lrck change,
    // the bit on the changing rise is the old slot's tail, the first W bits
    // after it form the word, a slot closing short of W bits is an error.
    bit           m_primed, m_active, m_done;
    logic         m_ch, m_prev_l;
    int           m_n;
    logic [W-1:0] m_bits;

    task automatic model_reset();
        m_primed = 0; m_active = 0; m_done = 0; m_n = 0; m_bits = '0;
    endtask

    task automatic model_rise(input logic l, input logic d);
        ev_t e;
        if (!m_primed) begin
            m_primed = 1; m_prev_l = l;
            return;
        end
        if (m_active && !m_done) begin
            m_bits = {m_bits[W-2:0], d};
            m_n++;
            if (m_n == W) begin
                e.is_err = 0; e.word = m_bits; e.ch = m_ch;
                exp_q.push_back(e);
                m_done = 1;
            end
        end
        if (l != m_prev_l) begin
            if (m_active && !m_done) begin
                e.is_err = 1; e.word = '0; e.ch = 0;
                exp_q.push_back(e);
            end
            m_active = 1; m_done = 0; m_ch = l; m_n = 0; m_bits = '0;
        end
        m_prev_l = l;
    endtask

    logic prev_bit;

    task automatic bit_period(input logic l, input logic d, input bit do_rst);
        @(negedge mck);
        bck = 1'b0; lrck = l; i2s_data = d;
        if (do_rst) begin
            rst_n = 1'b0;
            model_reset();
            repeat (3) @(negedge mck);
            rst_n = 1'b1;
            @(negedge mck);
        end else begin
            repeat (4) @(negedge mck);
        end
        bck = 1'b1;
        model_rise(l, d);
        repeat (3) @(negedge mck);
    endtask

    task automatic slot(input logic ch, input logic [W-1:0] w, input int len, input int rst_at);
        for (int i = 0; i < len; i++) begin
            bit_period(ch, prev_bit, i == rst_at);
            prev_bit = (i < W) ? w[W-1-i] : 1'b1;
        end
    endtask

    logic         rst_seen;
    logic [W-1:0] got_w[$];
    logic         got_c[$];
    int           err_total = 0;

    always @(posedge mck) rst_seen <= rst_n;

    initial begin : compare
        logic [W-1:0] last_s;
        logic         last_c, pv, pe;
        ev_t          e;
        last_s = '0; last_c = 0; pv = 0; pe = 0;
        forever begin
            @(negedge mck);
            if (rst_seen === 1'b0) begin
                check("rst_sample", sample, 0);
                check("rst_chan", chan, 0);
                check("rst_valid", sample_valid, 0);
                check("rst_err", frame_err, 0);
                last_s = '0; last_c = 0; pv = 0; pe = 0;
            end else if (rst_seen === 1'b1) begin
                check("valid_err_exclusive", sample_valid & frame_err, 0);
                if (sample_valid || frame_err) begin
                    check("pulse_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("pulse_kind_is_err", frame_err, e.is_err);
                        if (sample_valid && !e.is_err) begin
                            check("sample", sample, e.word);
                            check("chan", chan, e.ch);
                        end
                    end
                end
                if (sample_valid) begin
                    check("valid_single_cycle", pv, 0);
                    got_w.push_back(sample);
                    got_c.push_back(chan);
                    last_s = sample; last_c = chan;
                end else begin
                    check("sample_hold", sample, last_s);
                    check("chan_hold", chan, last_c);
                end
                if (frame_err) begin
                    check("err_single_cycle", pe, 0);
                    err_total++;
                end
                pv = sample_valid; pe = frame_err;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: stimulus did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [W-1:0] lit_w [9];
    logic         lit_c [9];

    initial begin : stim
        lit_w = '{24'hFFFFFF, 24'h000000, 24'hBFFFFF, 24'h3FFFFF,
                  24'hFFFFFF, 24'hBFFFFF, 24'h7FFFFF, 24'h3FFFFF, 24'h000000};
        lit_c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bck = 0; lrck = 1; i2s_data = 0; rst_n = 0; prev_bit = 0;
        model_reset();
        repeat (4) @(negedge mck);
        rst_n = 1;

        slot(1, 24'h000000, 4, -1);
        slot(0, 24'hFFFFFF, 24, -1);
        slot(1, 24'h000000, 24, -1);
        slot(0, 24'hBFFFFF, 32, -1);
        slot(1, 24'h7FFFFF, 11, -1);
        slot(0, 24'h3FFFFF, 24, -1);
        slot(1, 24'h123456, 24, 8);
        slot(0, 24'hFFFFFF, 24, -1);
        slot(1, 24'hBFFFFF, 24, -1);
        slot(0, 24'h7FFFFF, 24, -1);
        slot(1, 24'h3FFFFF, 24, -1);
        slot(0, 24'h000000, 24, -1);
        slot(1, 24'h000000, 4, -1);
        repeat (30) @(negedge mck);

        check("model_queue_drained", exp_q.size(), 0);
        check("num_samples", got_w.size(), 9);
        check("num_frame_err", err_total, 1);
        for (int i = 0; i < 9; i++) begin
            if (i < got_w.size()) begin
                check($sformatf("lit_sample_%0d", i), got_w[i], lit_w[i]);
                check($sformatf("lit_chan_%0d", i), got_c[i], lit_c[i]);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
